// File: rtl/divu_seq.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per cycle.
// Optional leading-zero early-out enabled by defining FEAT_DIV_EARLY_OUT_EN.
module divu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             valid_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] reminder_o
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, shreg_q, dvsr_q, quo_q, rmd_q;
  logic             busy_q, done_q, valid_q, dbz_q;

  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_d, shreg_d;
  logic [WIDTH-1:0] load_shreg;
  logic [CW-1:0]    load_cnt;
  logic             shortcut;

  // trial[WIDTH] set means the subtract went negative: restore
  assign rem_sh  = {rem_q, shreg_q[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dvsr_q};
  assign rem_d   = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign shreg_d = {shreg_q[WIDTH-2:0], ~trial[WIDTH]};

`ifdef FEAT_DIV_EARLY_OUT_EN
  function automatic logic [CW-1:0] lzc(input logic [WIDTH-1:0] v);
    lzc = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) lzc = CW'(WIDTH - 1 - i);
  endfunction

  logic [CW-1:0] lz;
  assign lz         = lzc(dividend_i);
  assign shortcut   = (dividend_i == '0) || (dividend_i < divisor_i);
  assign load_shreg = dividend_i << lz;
  assign load_cnt   = CW'(WIDTH) - lz;
`else
  assign shortcut   = 1'b0;
  assign load_shreg = dividend_i;
  assign load_cnt   = CW'(WIDTH);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      shreg_q <= '0;
      dvsr_q  <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (start_i) begin
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            dvsr_q  <= divisor_i;
            if (divisor_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              valid_q <= 1'b1;
              dbz_q   <= 1'b1;
              quo_q   <= '1;
              rmd_q   <= dividend_i;
            end else if (shortcut) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              valid_q <= 1'b1;
              quo_q   <= '0;
              rmd_q   <= dividend_i;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
              cnt_q   <= load_cnt;
              rem_q   <= '0;
              shreg_q <= load_shreg;
            end
          end
        end
        CALC: begin
          rem_q   <= rem_d;
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q - CW'(1);
          // final iteration writes the result straight into the output regs
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            quo_q   <= shreg_d;
            rmd_q   <= rem_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign valid_o    = valid_q;
  assign dbz_o      = dbz_q;
  assign quotient_o = quo_q;
  assign reminder_o = rmd_q;
endmodule

// File: tb/tb_divu_seq.sv
// Directed bench for divu_seq (WIDTH=32); latency expectations follow
// FEAT_DIV_EARLY_OUT_EN when it is defined.
module tb_divu_seq;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] dvd, dvs;
  logic        busy, done, valid, dbz;
  logic [31:0] quo, rmd;
  int          vecs = 0;
  int          errs = 0;

  divu_seq #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .dividend_i(dvd), .divisor_i(dvs),
    .busy_o(busy), .done_o(done), .valid_o(valid), .dbz_o(dbz),
    .quotient_o(quo), .reminder_o(rmd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
    int lz;
    if (b == 0) return 1;
`ifdef FEAT_DIV_EARLY_OUT_EN
    if (a == 0 || a < b) return 1;
    lz = 0;
    while (!a[31-lz]) lz++;
    return 33 - lz;
`else
    lz = 0;
    return 33 + lz;
`endif
  endfunction

  // called at a negedge; returns at the negedge of cycle t+1
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; dvd = a; dvs = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // called at cycle t+1; returns at the done cycle after checking the result
  task automatic finish(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ed);
    int lat = exp_lat(a, b);
    for (int k = 1; k < lat; k++) begin
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".done_early"}, done, 0);
      chk({tag, ".valid_low"}, valid, 0);
      @(negedge clk);
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy_done"}, busy, 0);
    chk({tag, ".valid"}, valid, 1);
    chk({tag, ".quo"}, quo, eq);
    chk({tag, ".rem"}, rmd, er);
    chk({tag, ".dbz"}, dbz, ed);
  endtask

  task automatic hold(input string tag, input logic [31:0] eq, input logic [31:0] er, input logic ed);
    @(negedge clk);
    chk({tag, ".done_drop"}, done, 0);
    chk({tag, ".valid_hold"}, valid, 1);
    chk({tag, ".quo_hold"}, quo, eq);
    chk({tag, ".rem_hold"}, rmd, er);
    chk({tag, ".dbz_hold"}, dbz, ed);
  endtask

  initial begin
    int lat, p, seen;
    rst = 1'b1; start = 1'b0; dvd = '0; dvs = '0;
    @(negedge clk); @(negedge clk);
    chk("rst.busy", busy, 0);  chk("rst.done", done, 0);
    chk("rst.valid", valid, 0); chk("rst.dbz", dbz, 0);
    chk("rst.quo", quo, 0);    chk("rst.rem", rmd, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(100, 7);              finish("b100_7", 100, 7, 14, 2, 0);
    hold("b100_7", 14, 2, 0);

    issue(32'hFFFFFFFF, 1);     finish("ff_1", 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 0);
    @(negedge clk);
    issue(32'h80000000, 32'hFFFFFFFF);
    finish("h80_ff", 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0);
    @(negedge clk);

    issue(1234, 0);             finish("dbz", 1234, 0, 32'hFFFFFFFF, 32'h4D2, 1);
    hold("dbz", 32'hFFFFFFFF, 32'h4D2, 1);
    issue(9, 3);
    chk("after_dbz.dbz_clr", dbz, 0);
    chk("after_dbz.valid_clr", valid, 0);
    finish("d9_3", 9, 3, 3, 0, 0);
    @(negedge clk);

    // second start lands while busy and must be ignored
    lat = exp_lat(50, 5);
    p = (lat > 10) ? 10 : lat - 1;
    issue(50, 5);
    for (int k = 1; k < lat; k++) begin
      chk("busyign.busy", busy, 1);
      chk("busyign.done_early", done, 0);
      start = (k == p); dvd = 7; dvs = 7;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busyign.done", done, 1);
    chk("busyign.quo", quo, 10);
    chk("busyign.rem", rmd, 0);
    issue(7, 7);               // presented in the DONE cycle
    finish("b2b7_7", 7, 7, 1, 0, 0);
    @(negedge clk);

    // reset mid-operation abandons the divide
    lat = exp_lat(1000, 3);
    p = (lat > 15) ? 15 : lat - 1;
    issue(1000, 3);
    for (int k = 1; k < p; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", busy, 0);  chk("midrst.done", done, 0);
    chk("midrst.valid", valid, 0); chk("midrst.dbz", dbz, 0);
    chk("midrst.quo", quo, 0);    chk("midrst.rem", rmd, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("midrst.no_done", seen, 0);
    issue(1000, 3);             finish("d1000_3", 1000, 3, 333, 1, 0);
    @(negedge clk);

    // start together with reset is dropped
    rst = 1'b1; start = 1'b1; dvd = 9; dvs = 3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rststart.busy", busy, 0);
    chk("rststart.valid", valid, 0);
    chk("rststart.done", done, 0);

    issue(5, 3);                finish("d5_3", 5, 3, 1, 2, 0);
    @(negedge clk);
    issue(3, 5);                finish("d3_5", 3, 5, 0, 3, 0);
    @(negedge clk);
    issue(0, 9);                finish("d0_9", 0, 9, 0, 0, 0);
    @(negedge clk);
    issue(7, 0);                finish("d7_0", 7, 0, 32'hFFFFFFFF, 7, 1);
    hold("d7_0", 32'hFFFFFFFF, 7, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
